// File: rtl/tcdm_log_xbar.sv
// NumIn x NumOut logarithmic crossbar: per-master bank decode and response mux, per-bank round-robin arbiter.
// Define TCDM_XBAR_ASSERT_EN to compile simulation-only parameter and grant checks.
module tcdm_log_xbar #(
  parameter int unsigned NumIn         = 4,
  parameter int unsigned NumOut        = 4,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1,
  parameter bit          WriteRespOn   = 1'b1,
  parameter bit          BroadCastOn   = 1'b0,
  parameter bit          ExtPrio       = 1'b0,
  localparam int unsigned InW  = (NumIn  > 1) ? $clog2(NumIn)  : 1,
  localparam int unsigned AddW = (NumOut > 1) ? $clog2(NumOut) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumOut-1:0][InW-1:0]           rr_i,
  input  logic [NumIn-1:0]                     req_i,
  input  logic [NumIn-1:0][AddW-1:0]           add_i,
  input  logic [NumIn-1:0]                     we_n_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]   wdata_i,
  output logic [NumIn-1:0]                     gnt_o,
  output logic [NumIn-1:0]                     vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]  rdata_o,
  input  logic [NumOut-1:0]                    gnt_i,
  output logic [NumOut-1:0]                    req_o,
  output logic [NumOut-1:0][ReqDataWidth-1:0]  wdata_o,
  input  logic [NumOut-1:0][RespDataWidth-1:0] rdata_i
);

  logic [NumOut-1:0][NumIn-1:0] req_line;
  logic [NumOut-1:0][NumIn-1:0] gnt_line;

  always_comb begin
    req_line = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      for (int unsigned j = 0; j < NumIn; j++) begin
        req_line[k][j] = BroadCastOn ? req_i[j] : (req_i[j] & (32'(add_i[j]) == k));
      end
    end
  end

  // An out-of-range bank index matches no k and therefore never sees a grant.
  always_comb begin
    gnt_o = '0;
    for (int unsigned j = 0; j < NumIn; j++) begin
      if (BroadCastOn) begin
        gnt_o[j] = 1'b1;
        for (int unsigned k = 0; k < NumOut; k++) gnt_o[j] = gnt_o[j] & gnt_line[k][j];
      end else begin
        for (int unsigned k = 0; k < NumOut; k++) begin
          if (32'(add_i[j]) == k) gnt_o[j] = gnt_line[k][j];
        end
      end
    end
  end

  for (genvar gk = 0; gk < NumOut; gk++) begin : g_slave
    if (NumIn == 1) begin : g_pass
      assign req_o[gk]    = req_line[gk][0];
      assign gnt_line[gk] = gnt_i[gk];
      assign wdata_o[gk]  = wdata_i[0];
    end else begin : g_arb
      logic [InW-1:0]   ptr_q;
      logic [InW-1:0]   prio;
      logic [InW-1:0]   winner;
      logic             any_req;
      logic [NumIn-1:0] gnt_k;

      assign prio = ExtPrio ? rr_i[gk] : ptr_q;

      always_comb begin
        int unsigned idx;
        idx     = 0;
        winner  = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NumIn; i++) begin
          idx = (32'(prio) + i) % NumIn;
          if (!any_req && req_line[gk][idx]) begin
            any_req = 1'b1;
            winner  = InW'(idx);
          end
        end
      end

      always_comb begin
        gnt_k = '0;
        for (int unsigned j = 0; j < NumIn; j++) begin
          gnt_k[j] = gnt_i[gk] & any_req & (32'(winner) == j);
        end
      end

      assign req_o[gk]    = any_req;
      assign gnt_line[gk] = gnt_k;
      assign wdata_o[gk]  = wdata_i[winner];

      // The pointer advances by one per handshake, not to winner+1.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ptr_q <= '0;
        end else if (any_req && gnt_i[gk]) begin
          ptr_q <= (ptr_q == InW'(NumIn - 1)) ? '0 : ptr_q + InW'(1);
        end
      end
    end
  end

  logic [NumIn-1:0][RespLat-1:0]           vld_q;
  logic [NumIn-1:0][RespLat-1:0][AddW-1:0] idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      for (int unsigned j = 0; j < NumIn; j++) begin
        vld_q[j][0] <= req_i[j] & gnt_o[j] & (WriteRespOn | ~we_n_i[j]);
        idx_q[j][0] <= add_i[j];
        for (int unsigned s = 1; s < RespLat; s++) begin
          vld_q[j][s] <= vld_q[j][s-1];
          idx_q[j][s] <= idx_q[j][s-1];
        end
      end
    end
  end

  always_comb begin
    vld_o   = '0;
    rdata_o = '0;
    for (int unsigned j = 0; j < NumIn; j++) begin
      vld_o[j] = vld_q[j][RespLat-1];
      for (int unsigned k = 0; k < NumOut; k++) begin
        if (32'(idx_q[j][RespLat-1]) == k) rdata_o[j] = rdata_i[k];
      end
    end
  end

`ifdef TCDM_XBAR_ASSERT_EN
  initial begin
    if (NumIn == 0 || NumOut == 0) $fatal(1, "tcdm_log_xbar: NumIn and NumOut must be > 0");
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      for (int unsigned j = 0; j < NumIn; j++) begin
        if (NumIn > 1) assert (!gnt_o[j] || req_i[j]) else $error("grant without request on master %0d", j);
      end
      for (int unsigned k = 0; k < NumOut; k++) begin
        assert ($onehot0(gnt_line[k])) else $error("multiple grants on slave %0d", k);
      end
      assert (!$isunknown(gnt_o) || $isunknown({req_i, add_i, gnt_i, rr_i}))
        else $error("gnt_o unknown with known inputs");
    end
  end
`else
`endif

endmodule

// File: tb/tb_tcdm_log_xbar.sv
// Table-driven bench for tcdm_log_xbar: combinational checks per vector, response scoreboard one cycle later.
// Three instances share stimulus: defaults, WriteRespOn=0 and ExtPrio=1.
module tb_tcdm_log_xbar;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [3:0][1:0]  rr_i;
  logic [3:0]       req_i;
  logic [3:0][1:0]  add_i;
  logic [3:0]       we_n_i;
  logic [3:0][31:0] wdata_i;
  logic [3:0]       gnt_i;
  logic [3:0][31:0] rdata_i;

  logic [3:0]       gnt_o_a, vld_o_a, req_o_a;
  logic [3:0][31:0] rdata_o_a, wdata_o_a;
  logic [3:0]       gnt_o_nw, vld_o_nw, req_o_nw;
  logic [3:0][31:0] rdata_o_nw, wdata_o_nw;
  logic [3:0]       gnt_o_ep, vld_o_ep, req_o_ep;
  logic [3:0][31:0] rdata_o_ep, wdata_o_ep;

  always #5 clk_i = ~clk_i;

  tcdm_log_xbar #(.NumIn(4), .NumOut(4), .RespLat(1), .WriteRespOn(1'b1), .ExtPrio(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rr_i(rr_i), .req_i(req_i), .add_i(add_i), .we_n_i(we_n_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o_a), .vld_o(vld_o_a), .rdata_o(rdata_o_a), .gnt_i(gnt_i),
    .req_o(req_o_a), .wdata_o(wdata_o_a), .rdata_i(rdata_i));

  tcdm_log_xbar #(.NumIn(4), .NumOut(4), .RespLat(1), .WriteRespOn(1'b0), .ExtPrio(1'b0)) dut_nw (
    .clk_i(clk_i), .rst_ni(rst_ni), .rr_i(rr_i), .req_i(req_i), .add_i(add_i), .we_n_i(we_n_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o_nw), .vld_o(vld_o_nw), .rdata_o(rdata_o_nw), .gnt_i(gnt_i),
    .req_o(req_o_nw), .wdata_o(wdata_o_nw), .rdata_i(rdata_i));

  tcdm_log_xbar #(.NumIn(4), .NumOut(4), .RespLat(1), .WriteRespOn(1'b1), .ExtPrio(1'b1)) dut_ep (
    .clk_i(clk_i), .rst_ni(rst_ni), .rr_i(rr_i), .req_i(req_i), .add_i(add_i), .we_n_i(we_n_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o_ep), .vld_o(vld_o_ep), .rdata_o(rdata_o_ep), .gnt_i(gnt_i),
    .req_o(req_o_ep), .wdata_o(wdata_o_ep), .rdata_i(rdata_i));

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [7:0] add;
    logic [3:0] we_n;
    logic [3:0] gnt;
    logic [3:0] x_req;
    logic [3:0] x_gnt;
    logic [7:0] x_win;
    logic       chk_ep;
    logic [3:0] x_gnt_ep;
  } vec_t;

  typedef struct {
    logic [3:0]       vld_a;
    logic [3:0]       vld_nw;
    logic [3:0][31:0] rd;
  } resp_t;

  vec_t  vecs[11];
  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [31:0] bank_data(input int unsigned k);
    return 32'hBA00_0000 + 32'(k) * 32'h111;
  endfunction

  function automatic logic [31:0] master_data(input int unsigned j);
    return 32'hC0DE_0000 + 32'(j);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_resp();
    resp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("vld_o", 32'(vld_o_a), 32'(e.vld_a));
    chk("vld_o no-write-resp", 32'(vld_o_nw), 32'(e.vld_nw));
    for (int unsigned j = 0; j < 4; j++) begin
      if (e.vld_a[j]) chk($sformatf("rdata_o[%0d]", j), rdata_o_a[j], e.rd[j]);
      if (e.vld_nw[j]) chk($sformatf("rdata_o no-write-resp[%0d]", j), rdata_o_nw[j], e.rd[j]);
    end
  endtask

  task automatic apply(input vec_t v, input int unsigned n);
    resp_t       e;
    logic [1:0]  win;
    logic [1:0]  a;
    req_i  = v.req;
    add_i  = v.add;
    we_n_i = v.we_n;
    gnt_i  = v.gnt;
    #2;
    chk($sformatf("v%0d req_o", n), 32'(req_o_a), 32'(v.x_req));
    chk($sformatf("v%0d gnt_o", n), 32'(gnt_o_a), 32'(v.x_gnt));
    chk($sformatf("v%0d gnt_o no-write-resp", n), 32'(gnt_o_nw), 32'(v.x_gnt));
    if (v.chk_ep) chk($sformatf("v%0d gnt_o ext-prio", n), 32'(gnt_o_ep), 32'(v.x_gnt_ep));
    for (int unsigned k = 0; k < 4; k++) begin
      win = v.x_win[2*k +: 2];
      if (v.x_req[k]) chk($sformatf("v%0d wdata_o[%0d]", n, k), wdata_o_a[k], master_data(32'(win)));
    end
    for (int unsigned j = 0; j < 4; j++) begin
      a = v.add[2*j +: 2];
      e.vld_a[j]  = v.x_gnt[j] & v.req[j];
      e.vld_nw[j] = v.x_gnt[j] & v.req[j] & ~v.we_n[j];
      e.rd[j]     = bank_data(32'(a));
    end
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    //            rst   req      add    we_n     gnt      x_req    x_gnt    x_win  ep    x_gnt_ep
    vecs[0]  = '{1'b0, 4'b0000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0001, 8'h02, 4'b0000, 4'b1111, 4'b0100, 4'b0001, 8'h00, 1'b0, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0010, 8'h0C, 4'b0010, 4'b1111, 4'b1000, 4'b0010, 8'h40, 1'b0, 4'b0000};
    vecs[3]  = '{1'b0, 4'b1111, 8'h1B, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 8'h1B, 1'b0, 4'b0000};
    // Contention on bank 1 from a fresh pointer: stalled cycles must not advance it.
    vecs[4]  = '{1'b1, 4'b1111, 8'h55, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 8'h00, 1'b0, 4'b0000};
    vecs[5]  = '{1'b0, 4'b1111, 8'h55, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 8'h00, 1'b0, 4'b0000};
    vecs[6]  = '{1'b0, 4'b1111, 8'h55, 4'b0000, 4'b0010, 4'b0010, 4'b0001, 8'h00, 1'b0, 4'b0000};
    vecs[7]  = '{1'b0, 4'b1111, 8'h55, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 8'h04, 1'b0, 4'b0000};
    vecs[8]  = '{1'b0, 4'b1111, 8'h55, 4'b0000, 4'b0010, 4'b0010, 4'b0100, 8'h08, 1'b0, 4'b0000};
    vecs[9]  = '{1'b0, 4'b1111, 8'h55, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 8'h0C, 1'b0, 4'b0000};
    vecs[10] = '{1'b0, 4'b1010, 8'h00, 4'b0000, 4'b1111, 4'b0001, 4'b0010, 8'h01, 1'b1, 4'b1000};

    rr_i    = '0;
    rr_i[0] = 2'd2;
    req_i   = '0;
    add_i   = '0;
    we_n_i  = '0;
    gnt_i   = '0;
    for (int unsigned k = 0; k < 4; k++) rdata_i[k] = bank_data(k);
    for (int unsigned j = 0; j < 4; j++) wdata_i[j] = master_data(j);

    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    chk("reset vld_o", 32'(vld_o_a), 32'h0);
    chk("reset gnt_o", 32'(gnt_o_a), 32'h0);
    chk("reset req_o", 32'(req_o_a), 32'h0);

    for (int unsigned i = 0; i < 11; i++) begin
      @(posedge clk_i);
      #1;
      check_resp();
      if (vecs[i].rst) begin
        req_i  = '0;
        rst_ni = 1'b0;
        #1;
        chk("mid-run reset vld_o", 32'(vld_o_a), 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        sb.delete();
      end
      apply(vecs[i], i);
    end
    @(posedge clk_i);
    #1;
    check_resp();

    // Granted read, then reset the cycle its response is presented.
    req_i    = 4'b0100;
    add_i[2] = 2'd1;
    we_n_i   = '0;
    gnt_i    = 4'b1111;
    #2;
    chk("rst-seq gnt_o", 32'(gnt_o_a), 32'h4);
    @(posedge clk_i);
    #1;
    chk("rst-seq vld_o before reset", 32'(vld_o_a), 32'h4);
    chk("rst-seq rdata_o[2]", rdata_o_a[2], bank_data(1));
    req_i  = '0;
    rst_ni = 1'b0;
    #1;
    chk("rst-seq vld_o in reset", 32'(vld_o_a), 32'h0);
    chk("rst-seq vld_o no-write-resp in reset", 32'(vld_o_nw), 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int unsigned c = 0; c < 2; c++) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("rst-seq vld_o after release %0d", c), 32'(vld_o_a), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
